// File: rtl/ts_tracklet_pkg.sv
// Shared constants and helpers for the tracklet counter bank.
package ts_tracklet_pkg;

  localparam int CNT_BITS_DEF = 6;
  localparam int NCHAN_MAX    = 16;

  // Low bit of channel ch's field in a vector that packs w-bit fields, channel 0 in the LSBs.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/ts_tracklet_cntr_bank_if.sv
// Strobe, control and snapshot bus of the tracklet counter bank.
interface ts_tracklet_cntr_bank_if
  import ts_tracklet_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int CNT_BITS = CNT_BITS_DEF,
  parameter int TOT_BITS = CNT_BITS + $clog2(NCHAN)
) ();

  logic                      clr;
  logic                      bx_start;
  logic [NCHAN-1:0]          x_valid;
  logic [NCHAN-1:0]          z_valid;
  logic [NCHAN*CNT_BITS-1:0] cnt;
  logic [NCHAN*CNT_BITS-1:0] snap_cnt;
  logic [NCHAN-1:0]          snap_ovf;
  logic [TOT_BITS-1:0]       snap_tot;
  logic                      snap_valid;

  modport master (
    output clr, bx_start, x_valid, z_valid,
    input  cnt, snap_cnt, snap_ovf, snap_tot, snap_valid
  );

  modport slave (
    input  clr, bx_start, x_valid, z_valid,
    output cnt, snap_cnt, snap_ovf, snap_tot, snap_valid
  );

endinterface

// File: rtl/ts_tracklet_chan_cntr.sv
// One channel: live tracklet counter, sticky overflow flag and crossing snapshot.
// TRACKLET_CNT_SAT_EN selects saturating counters; otherwise they wrap.
module ts_tracklet_chan_cntr #(
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                bx_start,
  input  logic                inc,
  output logic [CNT_BITS-1:0] cnt,
  output logic [CNT_BITS-1:0] snap_cnt,
  output logic                snap_ovf
);

  logic ovf;

  function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] v);
`ifdef TRACKLET_CNT_SAT_EN
    if (&v) return v;
`endif
    return v + CNT_BITS'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ovf      <= 1'b0;
      snap_cnt <= '0;
      snap_ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (bx_start) begin
      // The boundary-cycle tracklet opens the new crossing.
      snap_cnt <= cnt;
      snap_ovf <= ovf;
      cnt      <= CNT_BITS'(inc);
      ovf      <= 1'b0;
    end else if (inc) begin
      cnt <= cnt_next(cnt);
      ovf <= ovf | (&cnt);
    end
  end

endmodule

// File: rtl/ts_tracklet_cntr_bank.sv
// Tracklet counter bank: NCHAN channel counters plus registered snapshot total.
// Build option TRACKLET_CNT_SAT_EN (saturating counters) lives in ts_tracklet_chan_cntr.
module ts_tracklet_cntr_bank
  import ts_tracklet_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int CNT_BITS = CNT_BITS_DEF,
  parameter int TOT_BITS = CNT_BITS + $clog2(NCHAN)
) (
  input logic                    clk,
  input logic                    rst_n,
  ts_tracklet_cntr_bank_if.slave bus
);

  logic [NCHAN*CNT_BITS-1:0] cnt_all;
  logic [NCHAN*CNT_BITS-1:0] snap_cnt_all;
  logic [NCHAN-1:0]          snap_ovf_all;
  logic                      vld_p0;
  logic                      vld_p1;
  logic [TOT_BITS-1:0]       tot_sum_p1;
  logic [TOT_BITS-1:0]       snap_tot_p2;
  logic                      vld_p2;

  // Stage p0 -> p1: per-channel counters and snapshot capture
  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    ts_tracklet_chan_cntr #(.CNT_BITS(CNT_BITS)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .bx_start (bus.bx_start),
      .inc      (bus.x_valid[g] & bus.z_valid[g]),
      .cnt      (cnt_all[slice_lo(g, CNT_BITS) +: CNT_BITS]),
      .snap_cnt (snap_cnt_all[slice_lo(g, CNT_BITS) +: CNT_BITS]),
      .snap_ovf (snap_ovf_all[g])
    );
  end

  assign vld_p0 = bus.bx_start & ~bus.clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // Stage p1 -> p2: total of the freshly captured snapshot
  always_comb begin
    tot_sum_p1 = '0;
    for (int i = 0; i < NCHAN; i++)
      tot_sum_p1 = tot_sum_p1 + TOT_BITS'(snap_cnt_all[slice_lo(i, CNT_BITS) +: CNT_BITS]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_tot_p2 <= '0;
      vld_p2      <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) snap_tot_p2 <= tot_sum_p1;
    end
  end

  assign bus.cnt        = cnt_all;
  assign bus.snap_cnt   = snap_cnt_all;
  assign bus.snap_ovf   = snap_ovf_all;
  assign bus.snap_tot   = snap_tot_p2;
  assign bus.snap_valid = vld_p2;

endmodule

// File: tb/tb_ts_tracklet_cntr_bank.sv
// Scoreboard bench for ts_tracklet_cntr_bank (NCHAN=4, CNT_BITS=6).
module tb_ts_tracklet_cntr_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ts_tracklet_cntr_bank_if #(.NCHAN(4), .CNT_BITS(6), .TOT_BITS(8)) bus ();

  ts_tracklet_cntr_bank #(.NCHAN(4), .CNT_BITS(6), .TOT_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] c;
    logic [3:0]  o;
    logic [7:0]  t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  task automatic push(input logic [23:0] c, input logic [3:0] o, input logic [7:0] t);
    exp_t e;
    e.c = c; e.o = o; e.t = t;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: snap_cnt/snap_ovf are checked as they stood the cycle before snap_valid.
  logic [23:0] prev_c;
  logic [3:0]  prev_o;
  initial begin
    prev_c = '0;
    prev_o = '0;
    forever begin
      @(negedge clk);
      if (bus.snap_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_snap_valid actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("snap_cnt", 32'(prev_c), 32'(e.c));
          chk("snap_ovf", 32'(prev_o), 32'(e.o));
          chk("snap_tot", 32'(bus.snap_tot), 32'(e.t));
        end
      end
      prev_c = bus.snap_cnt;
      prev_o = bus.snap_ovf;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.clr = 0; bus.bx_start = 0; bus.x_valid = 0; bus.z_valid = 0;

    // 1. reset with random strobes
    for (int i = 0; i < 6; i++) begin
      bus.x_valid = 4'($urandom); bus.z_valid = 4'($urandom); bus.bx_start = 1'($urandom);
      tick();
    end
    chk("rst_cnt", 32'(bus.cnt), 0);
    chk("rst_snap_cnt", 32'(bus.snap_cnt), 0);
    chk("rst_snap_ovf", 32'(bus.snap_ovf), 0);
    chk("rst_snap_tot", 32'(bus.snap_tot), 0);
    chk("rst_snap_valid", 32'(bus.snap_valid), 0);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 0;
    rst_n = 1;
    tick();
    bus.x_valid = 4'b0100; bus.z_valid = 4'b0100;
    tick(5);
    chk("t1_live", 32'(bus.cnt), 32'(pk(0, 0, 5, 0)));
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
    push(pk(0, 0, 5, 0), 4'b0000, 8'd5);
    tick();
    bus.bx_start = 0;
    chk("t1_live_after_bx", 32'(bus.cnt), 0);
    tick(4);

    // 2. single-strobe rejection
    bus.x_valid = 4'b0001; tick(10);
    bus.x_valid = 0; bus.z_valid = 4'b0001; tick(10);
    bus.z_valid = 0;
    chk("t2_cnt0", 32'(bus.cnt), 0);

    // 3. boundary increment
    bus.x_valid = 4'b0010; bus.z_valid = 4'b0010;
    tick(3);
    bus.bx_start = 1;
    push(pk(0, 3, 0, 0), 4'b0000, 8'd3);
    tick();
    bus.bx_start = 0; bus.x_valid = 0; bus.z_valid = 0;
    chk("t3_live", 32'(bus.cnt), 32'(pk(0, 1, 0, 0)));
    tick(4);

    // 4. overflow on channel 3
    bus.clr = 1; tick(); bus.clr = 0;
    chk("t4_clr", 32'(bus.cnt), 0);
    bus.x_valid = 4'b1000; bus.z_valid = 4'b1000;
    tick(70);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
`ifdef TRACKLET_CNT_SAT_EN
    push(pk(0, 0, 0, 63), 4'b1000, 8'd63);
`else
    push(pk(0, 0, 0, 6), 4'b1000, 8'd6);
`endif
    tick();
    bus.bx_start = 0;
    chk("t4_live_after_bx", 32'(bus.cnt), 0);
    bus.x_valid = 4'b0001; bus.z_valid = 4'b0001;
    tick(2);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
    push(pk(2, 0, 0, 0), 4'b0000, 8'd2);
    tick();
    bus.bx_start = 0;
    tick(4);

    // 5. clr beats bx_start
    bus.x_valid = 4'b1011; bus.z_valid = 4'b1011; tick(2);
    bus.x_valid = 4'b1001; bus.z_valid = 4'b1001; tick(5);
    bus.x_valid = 4'b1000; bus.z_valid = 4'b1000; tick(2);
    bus.x_valid = 0; bus.z_valid = 0;
    chk("t5_live", 32'(bus.cnt), 32'(pk(7, 2, 0, 9)));
    bus.clr = 1; bus.bx_start = 1;
    tick();
    bus.clr = 0; bus.bx_start = 0;
    chk("t5_cnt_cleared", 32'(bus.cnt), 0);
    tick(3);
    chk("t5_snap_cnt_kept", 32'(bus.snap_cnt), 32'(pk(2, 0, 0, 0)));
    chk("t5_snap_ovf_kept", 32'(bus.snap_ovf), 0);
    chk("t5_snap_tot_kept", 32'(bus.snap_tot), 2);

    // 6. back-to-back crossings
    bus.x_valid = 4'b1111; bus.z_valid = 4'b1111; tick(4);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
    push(pk(4, 4, 4, 4), 4'b0000, 8'd16);
    tick();
    push(pk(0, 0, 0, 0), 4'b0000, 8'd0);
    tick();
    bus.bx_start = 0;
    tick(4);

    // 7. reset mid-crossing drops the pending snapshot
    bus.x_valid = 4'b0001; bus.z_valid = 4'b0001; tick(3);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
    tick();
    bus.bx_start = 0;
    rst_n = 0;
    #1;
    chk("t7_rst_cnt", 32'(bus.cnt), 0);
    chk("t7_rst_snap_cnt", 32'(bus.snap_cnt), 0);
    tick(2);
    rst_n = 1;
    tick();
    bus.x_valid = 4'b0010; bus.z_valid = 4'b0010; tick(2);
    bus.x_valid = 0; bus.z_valid = 0; bus.bx_start = 1;
    push(pk(0, 2, 0, 0), 4'b0000, 8'd2);
    tick();
    bus.bx_start = 0;
    tick(5);

    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_tracklet_cntr_bank.md
# ts_tracklet_cntr_bank

Multi-channel tracklet counter bank for the tracklet-finding stage. It keeps one up-counter per tracklet FIFO and counts an accepted tracklet whenever both the x and z match strobes of a channel are valid in the same cycle. At each bunch-crossing boundary it snapshots every channel count, its overflow flag and a registered all-channel total, then restarts counting. It sits beside the tracklet FIFOs and feeds the crossing-summary and readout logic.

## Interface
Parameters:
- `NCHAN`, default 4: number of tracklet channels (1–16).
- `CNT_BITS`, default 6: width of each per-channel count.
- `TOT_BITS`, default `CNT_BITS + $clog2(NCHAN)`: width of the summed total.

Ports:
- `clk`, input, 1: fast processing clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clr`, input, 1: synchronous clear of the live counters and flags. No snapshot is taken.
- `bx_start`, input, 1: first cycle of a new crossing. Closes the previous crossing.
- `x_valid`, input, `NCHAN`: per-channel x-match strobe.
- `z_valid`, input, `NCHAN`: per-channel z-match strobe.
- `cnt`, output, `NCHAN*CNT_BITS`: live counts, packed with channel 0 in the LSBs.
- `snap_cnt`, output, `NCHAN*CNT_BITS`: counts captured for the closed crossing.
- `snap_ovf`, output, `NCHAN`: per-channel overflow flags captured for the closed crossing.
- `snap_tot`, output, `TOT_BITS`: sum of `snap_cnt` over all channels.
- `snap_valid`, output, 1: one-cycle pulse when `snap_tot` becomes valid.

## Operation
- Increment condition for channel i: `inc[i] = x_valid[i] & z_valid[i]`.
- Per-channel live counter update, in priority order:
  1. `clr` → counter = 0, `ovf` = 0.
  2. `bx_start` → counter = `inc[i]`, `ovf` = 0. The boundary-cycle tracklet belongs to the new crossing.
  3. `inc[i]` → counter + 1.
  4. Otherwise → hold.
- Overflow: an increment at all-ones sets the sticky `ovf[i]`. The counter value on overflow depends on the configuration macro below.
- Snapshot on `bx_start` (when `clr` is low):
  - `snap_cnt[i]` ← the pre-update counter value.
  - `snap_ovf[i]` ← the pre-update `ovf[i]`.
- `clr` and `bx_start` in the same cycle: `clr` wins. Counters and flags go to 0, no snapshot is taken, and no `snap_valid` is issued.
- Total: `snap_tot` is registered one cycle after the snapshot as an unsigned zero-extended sum of the `snap_cnt` fields. `snap_valid` pulses high in the same cycle `snap_tot` updates.
- Two `bx_start` pulses on consecutive cycles:
  - Both snapshots are taken.
  - The second one captures 0 or 1 per channel.
  - `snap_valid` pulses on two consecutive cycles.
- A `bx_start` pulse occurring before the first crossing boundary after reset snapshots zeros. This is legal.

## Timing
- Reset values (`rst_n` low, asynchronous): `cnt`, `ovf`, `snap_cnt`, `snap_ovf`, `snap_tot` and `snap_valid` are all 0.
- `cnt` is registered: a strobe in cycle N is visible on `cnt` in cycle N+1.
- `snap_cnt` and `snap_ovf` are valid from cycle N+1 for a `bx_start` in cycle N.
- `snap_tot` and `snap_valid` appear in cycle N+2.
- The snapshot registers hold until the next `bx_start`. They are not cleared by `clr`.
- Reset asserted mid-crossing:
  - All state clears immediately.
  - A pending `snap_valid` is dropped.
  - The first `bx_start` after reset snapshots the counts accumulated since reset.
- Minimum `bx_start` spacing is 1 cycle; there is no throughput restriction.

## Configuration
- Macro: `TRACKLET_CNT_SAT_EN`.
- With the macro defined: counters saturate at all-ones. Further increments hold the value and set `ovf`.
- Without it: counters wrap from all-ones to 0 and set `ovf`. `snap_ovf` is the only indication that the count is incomplete.

## Structure
- The shared package `ts_tracklet_pkg` holds:
  - the default `CNT_BITS` (replacing the `TRACKLET_CNT_BITS` constant);
  - the maximum `NCHAN`;
  - the packed-slice helper function used to index per-channel fields.
- One sub-module, `ts_tracklet_chan_cntr`, contains a single channel's counter, `ovf` flag and snapshot registers. It is instantiated `NCHAN` times by a generate loop.
- The top level holds the total adder and the `snap_valid` pipeline.

## Test plan
All cases use `NCHAN`=4 and `CNT_BITS`=6.
1. Reset: hold `rst_n` low with random strobes → all outputs are 0. Release it, strobe channel 2 both-valid for 5 cycles, then `bx_start` → `snap_cnt[2]`=5 and the other channels are 0; two cycles later `snap_tot`=5 and `snap_valid` is a 1-cycle pulse.
2. Single-strobe rejection: `x_valid` only on channel 0 for 10 cycles, then `z_valid` only for 10 cycles → `cnt[0]` stays 0.
3. Boundary increment: channel 1 counts 3, then `bx_start` coincides with an increment → `snap_cnt[1]`=3 and live `cnt[1]`=1 on the next cycle.
4. Overflow, run twice (macro on and off): 70 increments on channel 3 followed by `bx_start`.
   - With the macro: `snap_cnt[3]`=63.
   - Without it: `snap_cnt[3]`=6.
   - In both builds `snap_ovf[3]`=1, and `ovf` is cleared in the new crossing.
5. Clear priority: `clr` and `bx_start` in the same cycle with live counts 7/2/0/9 → counts go to 0, the snapshot registers keep their previous values, and no `snap_valid` is issued.
6. Back-to-back crossings: `bx_start` on cycles N and N+1 with counts 4/4/4/4 → `snap_tot`=16 at N+2, then 0 at N+3 (no increments during cycle N), and `snap_valid` is high on both cycles.
